// File: rtl/hls_macc_pkg.sv
// Shared types for the hls_macc result collector.
//   DATA_W        : width of every kernel result and stream word
//   res_rec_t     : one captured result record {out1, out2, out3, ret}
//   word_idx_e    : serializer word index (W_CSUM only emitted with MACC_COLL_CHECKSUM_EN)
//   start_state_e : kernel start/handshake FSM states
package hls_macc_pkg;

    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] out1;
        logic [DATA_W-1:0] out2;
        logic [DATA_W-1:0] out3;
        logic [DATA_W-1:0] ret;
    } res_rec_t;

    typedef enum logic [2:0] {
        W_OUT1 = 3'd0,
        W_OUT2 = 3'd1,
        W_OUT3 = 3'd2,
        W_RET  = 3'd3,
        W_CSUM = 3'd4
    } word_idx_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_WAIT_DONE = 2'd2
    } start_state_e;

endpackage

// File: rtl/hls_macc_res_fifo.sv
// DEPTH-entry synchronous FIFO of result records.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write wr_data (accepted when not full, or when full with a same-cycle pop)
//   wr_data    : record to store
//   pop        : retire the head record (ignored when empty)
//   rd_data_c  : head record (combinational view of storage)
//   full_c     : count == DEPTH
//   empty_c    : count == 0
//   count      : number of stored records (registered)
module hls_macc_res_fifo
    import hls_macc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  res_rec_t                 wr_data,
    input  logic                     pop,
    output res_rec_t                 rd_data_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    res_rec_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty_c;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push   = push && (!full_c || do_pop);
    assign rd_data_c = mem[rd_ptr];

    // Record storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hls_macc_result_collector.sv
// Downstream stage of the hls_macc kernel: issues ap_start against FIFO credit,
// captures out1/out2/out3 (on their vld strobes) and ap_return (on ap_done) as one
// record, buffers records, and drains them as a 32-bit valid/ready word stream.
// Optional feature macro: MACC_COLL_CHECKSUM_EN appends a 5th word
// out1^out2^out3^ret to every record (m_last moves to that word).
// Ports:
//   ap_clk, ap_rst         : clock, asynchronous active-high reset
//   start_req              : upstream request for one kernel run (level)
//   mac_ap_start           : kernel ap_start (registered)
//   mac_ap_ready/done      : kernel handshake inputs
//   mac_ap_return          : kernel return value, sampled on ap_done
//   mac_outN, mac_outN_vld : kernel outputs with their valid strobes
//   m_data/m_valid/m_last  : output word stream (registered), m_ready from consumer
//   busy                   : a kernel run is in flight
//   err_sticky             : protocol error seen since reset
module hls_macc_result_collector
    import hls_macc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start_req,
    output logic              mac_ap_start,
    input  logic              mac_ap_ready,
    input  logic              mac_ap_done,
    input  logic [DATA_W-1:0] mac_ap_return,
    input  logic [DATA_W-1:0] mac_out1,
    input  logic [DATA_W-1:0] mac_out2,
    input  logic [DATA_W-1:0] mac_out3,
    input  logic              mac_out1_vld,
    input  logic              mac_out2_vld,
    input  logic              mac_out3_vld,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              err_sticky
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

`ifdef MACC_COLL_CHECKSUM_EN
    localparam word_idx_e LAST_W = W_CSUM;
`else
    localparam word_idx_e LAST_W = W_RET;
`endif

    // Select one word of a record for the output stream.
    function automatic logic [DATA_W-1:0] rec_word(input res_rec_t rec, input word_idx_e idx);
        logic [DATA_W-1:0] w;
        w = '0;
        case (idx)
            W_OUT1:  w = rec.out1;
            W_OUT2:  w = rec.out2;
            W_OUT3:  w = rec.out3;
            W_RET:   w = rec.ret;
`ifdef MACC_COLL_CHECKSUM_EN
            W_CSUM:  w = rec.out1 ^ rec.out2 ^ rec.out3 ^ rec.ret;
`endif
            default: w = '0;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    res_rec_t          push_rec;
    res_rec_t          fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    hls_macc_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .push      (fifo_push),
        .wr_data   (push_rec),
        .pop       (fifo_pop),
        .rd_data_c (fifo_head),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Start FSM: state register
    // ------------------------------------------------------------------
    start_state_e state_q;
    start_state_e state_d;
    logic         start_d;
    logic         busy_d;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            mac_ap_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mac_ap_start <= start_d;
            busy         <= busy_d;
        end
    end

    // Start FSM: next state; a run is only launched while a FIFO slot is free,
    // so the single in-flight run can always push its record.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req && (fifo_count < CW'(DEPTH))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (mac_ap_done) begin
                    state_d = S_IDLE;
                end else if (mac_ap_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mac_ap_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Capture staging
    // ------------------------------------------------------------------
    logic [2:0][DATA_W-1:0] out_vec;
    logic [2:0]             vld_vec;
    logic [2:0][DATA_W-1:0] stage_q;
    logic [2:0]             flag_q;
    logic                   push_req;
    logic                   missing;
    logic                   spurious;
    logic                   drop;

    assign out_vec = {mac_out3, mac_out2, mac_out1};
    assign vld_vec = {mac_out3_vld, mac_out2_vld, mac_out1_vld};

    // Build the record; a same-cycle vld bypasses the staging register.
    always_comb begin
        push_rec.out1 = vld_vec[0] ? out_vec[0] : stage_q[0];
        push_rec.out2 = vld_vec[1] ? out_vec[1] : stage_q[1];
        push_rec.out3 = vld_vec[2] ? out_vec[2] : stage_q[2];
        push_rec.ret  = mac_ap_return;
        push_req      = mac_ap_done && busy;
        missing       = |(~vld_vec & ~flag_q);
        spurious      = !busy && (mac_ap_done || (|vld_vec));
        drop          = push_req && fifo_full && !fifo_pop;
        fifo_push     = push_req && !drop;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stage_q    <= '0;
            flag_q     <= '0;
            err_sticky <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (busy && vld_vec[i]) begin
                    stage_q[i] <= out_vec[i];
                end
                if (push_req) begin
                    flag_q[i] <= 1'b0;
                end else if (busy && vld_vec[i]) begin
                    flag_q[i] <= 1'b1;
                end
            end
            if ((push_req && (missing || drop)) || spurious) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer: presents the head record word by word, pops after the last
    // ------------------------------------------------------------------
    word_idx_e         widx_q;
    word_idx_e         widx_d;
    word_idx_e         widx_nxt;
    logic              valid_d;
    logic              last_d;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        valid_d  = m_valid;
        last_d   = m_last;
        data_d   = m_data;
        widx_d   = widx_q;
        fifo_pop = 1'b0;
        widx_nxt = word_idx_e'(3'(widx_q) + 3'd1);
        if (!m_valid) begin
            if (!fifo_empty) begin
                valid_d = 1'b1;
                widx_d  = W_OUT1;
                data_d  = rec_word(fifo_head, W_OUT1);
                last_d  = 1'b0;
            end
        end else if (m_ready) begin
            if (m_last) begin
                fifo_pop = 1'b1;
                valid_d  = 1'b0;
                last_d   = 1'b0;
            end else begin
                widx_d = widx_nxt;
                data_d = rec_word(fifo_head, widx_nxt);
                last_d = (widx_nxt == LAST_W);
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            widx_q  <= W_OUT1;
        end else begin
            m_valid <= valid_d;
            m_last  <= last_d;
            m_data  <= data_d;
            widx_q  <= widx_d;
        end
    end

endmodule

// File: tb/tb_hls_macc_result_collector.sv
// Directed bench for hls_macc_result_collector: reset, single run, start
// handshake, backpressure with credit gating, streaming, protocol errors and
// reset in the middle of a drain.
module tb_hls_macc_result_collector;

    localparam int unsigned DEPTH = 4;
`ifdef MACC_COLL_CHECKSUM_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif

    logic        ap_clk;
    logic        ap_rst;
    logic        start_req;
    logic        mac_ap_start;
    logic        mac_ap_ready;
    logic        mac_ap_done;
    logic [31:0] mac_ap_return;
    logic [31:0] mac_out1;
    logic [31:0] mac_out2;
    logic [31:0] mac_out3;
    logic        mac_out1_vld;
    logic        mac_out2_vld;
    logic        mac_out3_vld;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        err_sticky;

    int checks   = 0;
    int failures = 0;

    hls_macc_result_collector #(
        .DEPTH (DEPTH)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .start_req     (start_req),
        .mac_ap_start  (mac_ap_start),
        .mac_ap_ready  (mac_ap_ready),
        .mac_ap_done   (mac_ap_done),
        .mac_ap_return (mac_ap_return),
        .mac_out1      (mac_out1),
        .mac_out2      (mac_out2),
        .mac_out3      (mac_out3),
        .mac_out1_vld  (mac_out1_vld),
        .mac_out2_vld  (mac_out2_vld),
        .mac_out3_vld  (mac_out3_vld),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .err_sticky    (err_sticky)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vlds(input logic [2:0] vmask, input logic on);
        mac_out1_vld = vmask[0] & on;
        mac_out2_vld = vmask[1] & on;
        mac_out3_vld = vmask[2] & on;
    endtask

    // Kernel model: answer ap_start after rdly extra cycles, then outputs, then done.
    task automatic run_kernel(input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] o3, input logic [31:0] ret,
                              input int rdly, input logic [2:0] vmask,
                              input bit vld_on_done, input bit drop_req, input string tag);
        int n = 0;
        while (mac_ap_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_start_seen"}, 32'(mac_ap_start), 32'd1);
        if (mac_ap_start !== 1'b1) return;
        if (drop_req) start_req = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            step();
            chk({tag, "_start_held"}, 32'(mac_ap_start), 32'd1);
        end
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        mac_ap_ready = 1'b1;
        step();
        mac_ap_ready = 1'b0;
        chk({tag, "_start_drop"}, 32'(mac_ap_start), 32'd0);
        chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
        mac_out1 = o1;
        mac_out2 = vmask[1] ? o2 : 32'hDEAD_BEEF;
        mac_out3 = o3;
        if (!vld_on_done) begin
            set_vlds(vmask, 1'b1);
            step();
            set_vlds(vmask, 1'b0);
        end
        mac_ap_return = ret;
        mac_ap_done   = 1'b1;
        if (vld_on_done) set_vlds(vmask, 1'b1);
        step();
        mac_ap_done = 1'b0;
        set_vlds(vmask, 1'b0);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    // Stream consumer: take one record with m_ready held high and check each word.
    task automatic collect(input logic [31:0] o1, input logic [31:0] o2,
                           input logic [31:0] o3, input logic [31:0] ret, input string tag);
        logic [31:0] w [5];
        int n = 0;
        w[0] = o1;
        w[1] = o2;
        w[2] = o3;
        w[3] = ret;
        w[4] = o1 ^ o2 ^ o3 ^ ret;
        m_ready = 1'b1;
        while (m_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s_w%0d_valid", tag, i), 32'(m_valid), 32'd1);
            chk($sformatf("%s_w%0d_data", tag, i), m_data, w[i]);
            chk($sformatf("%s_w%0d_last", tag, i), 32'(m_last), 32'(i == NW - 1));
            step();
        end
    endtask

    initial begin
        ap_rst        = 1'b1;
        start_req     = 1'b0;
        mac_ap_ready  = 1'b0;
        mac_ap_done   = 1'b0;
        mac_ap_return = '0;
        mac_out1      = '0;
        mac_out2      = '0;
        mac_out3      = '0;
        mac_out1_vld  = 1'b0;
        mac_out2_vld  = 1'b0;
        mac_out3_vld  = 1'b0;
        m_ready       = 1'b0;

        // Reset state
        #3;
        chk("rst_start", 32'(mac_ap_start), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        step();
        step();
        ap_rst = 1'b0;
        step();
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_start", 32'(mac_ap_start), 32'd0);

        // Single run and push-to-valid latency
        start_req = 1'b1;
        run_kernel(32'h11, 32'h22, 32'h33, 32'h44, 0, 3'b111, 1'b0, 1'b1, "t2");
        chk("t2_lat0", 32'(m_valid), 32'd0);
        step();
        chk("t2_lat1", 32'(m_valid), 32'd1);
        collect(32'h11, 32'h22, 32'h33, 32'h44, "t2");

        // Delayed ap_ready, start_req dropped early, vld strobes on the done cycle
        start_req = 1'b1;
        run_kernel(32'hA1, 32'hA2, 32'hA3, 32'hA4, 3, 3'b111, 1'b1, 1'b1, "t4");
        step();
        chk("t4_no_restart", 32'(mac_ap_start), 32'd0);
        collect(32'hA1, 32'hA2, 32'hA3, 32'hA4, "t4");

        // Backpressure: four records fill the FIFO, no further start
        m_ready   = 1'b0;
        start_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_kernel(32'h3100 + 32'(k), 32'h3200 + 32'(k), 32'h3300 + 32'(k),
                       32'h3400 + 32'(k), 0, 3'b111, 1'b0, 1'b0, "t3");
        end
        repeat (6) step();
        chk("t3_full_start", 32'(mac_ap_start), 32'd0);
        chk("t3_full_busy", 32'(busy), 32'd0);
        chk("t3_hold_valid", 32'(m_valid), 32'd1);
        chk("t3_hold_data", m_data, 32'h3100);
        fork
            begin
                run_kernel(32'h3104, 32'h3204, 32'h3304, 32'h3404, 0, 3'b111, 1'b0, 1'b0, "t3k4");
                run_kernel(32'h3105, 32'h3205, 32'h3305, 32'h3405, 1, 3'b111, 1'b0, 1'b1, "t3k5");
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    collect(32'h3100 + 32'(j), 32'h3200 + 32'(j), 32'h3300 + 32'(j),
                            32'h3400 + 32'(j), $sformatf("t3r%0d", j));
                end
            end
        join

        // Continuous streaming across pointer wrap
        start_req = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    run_kernel(32'h6100 + 32'(k), 32'h6200 + 32'(k), 32'h6300 + 32'(k),
                               32'h6400 + 32'(k), k % 2, 3'b111, 1'(k % 2), 1'(k == 3), "t6");
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    collect(32'h6100 + 32'(j), 32'h6200 + 32'(j), 32'h6300 + 32'(j),
                            32'h6400 + 32'(j), $sformatf("t6r%0d", j));
                end
            end
        join

        // Missing out2 vld: stale stage value used, error flagged
        chk("t5_err_pre", 32'(err_sticky), 32'd0);
        start_req = 1'b1;
        run_kernel(32'h51, 32'h52, 32'h53, 32'h54, 0, 3'b101, 1'b0, 1'b1, "t5");
        chk("t5_err_missing", 32'(err_sticky), 32'd1);
        collect(32'h51, 32'h6203, 32'h53, 32'h54, "t5");

        // Reset clears the sticky error; spurious done while idle is flagged, not pushed
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        step();
        chk("t5_err_cleared", 32'(err_sticky), 32'd0);
        mac_ap_done = 1'b1;
        step();
        mac_ap_done = 1'b0;
        chk("t5_err_spurious", 32'(err_sticky), 32'd1);
        repeat (4) step();
        chk("t5_no_push", 32'(m_valid), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a drain
        start_req = 1'b1;
        m_ready   = 1'b1;
        run_kernel(32'h71, 32'h72, 32'h73, 32'h74, 0, 3'b111, 1'b0, 1'b1, "t1");
        step();
        chk("t1_w0", m_data, 32'h71);
        step();
        step();
        chk("t1_w2", m_data, 32'h73);
        chk("t1_w2_valid", 32'(m_valid), 32'd1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("t1_rst_valid", 32'(m_valid), 32'd0);
        chk("t1_rst_last", 32'(m_last), 32'd0);
        chk("t1_rst_data", m_data, 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_start", 32'(mac_ap_start), 32'd0);
        chk("t1_rst_err", 32'(err_sticky), 32'd0);
        step();
        step();
        ap_rst = 1'b0;
        repeat (3) step();
        chk("t1_post_valid", 32'(m_valid), 32'd0);
        chk("t1_post_data", m_data, 32'd0);
        chk("t1_post_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
